// File: rtl/mips_pkg.sv
// Shared definitions for the five-stage MIPS core.
// Address map, exception codes and inter-stage bundles.
package mips_pkg;

  localparam logic [31:0] PC_RESET = 32'h0000_3000;
  localparam logic [31:0] IM_LO    = 32'h0000_3000;
  localparam logic [31:0] IM_HI    = 32'h0000_6FFC;

  localparam logic [4:0] EXC_NONE = 5'd0;
  localparam logic [4:0] EXC_ADEL = 5'd4;
  localparam logic [4:0] EXC_RI   = 5'd10;
  localparam logic [4:0] EXC_OV   = 5'd12;

  localparam logic [31:0] NOP = 32'h0;

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc;
    logic [31:0] pc8;
    logic        bd;
    logic [4:0]  exc;
    logic        valid;
  } if_id_t;

endpackage

// File: rtl/if_id_reg_if.sv
// Fetch-to-decode bundle: F-side inputs, D-side outputs.
// master drives F and watches D; slave is the pipeline register.
interface if_id_reg_if;
  logic        Stall;
  logic        Flush;
  logic [31:0] Instr_F;
  logic [31:0] PC_F;
  logic [31:0] PC8_F;
  logic        BD_F;
  logic [31:0] Instr_D;
  logic [31:0] PC_D;
  logic [31:0] PC8_D;
  logic        BD_D;
  logic [4:0]  ExcCode_D;
  logic        Valid_D;
  logic [15:0] StallCnt;

  modport master (
    output Stall, Flush, Instr_F, PC_F, PC8_F, BD_F,
    input  Instr_D, PC_D, PC8_D, BD_D,
    input  ExcCode_D, Valid_D, StallCnt
  );

  modport slave (
    input  Stall, Flush, Instr_F, PC_F, PC8_F, BD_F,
    output Instr_D, PC_D, PC8_D, BD_D,
    output ExcCode_D, Valid_D, StallCnt
  );
endinterface

// File: rtl/fetch_exc_chk.sv
// Address-error classifier: misaligned or outside [LO, HI].
// Bounds are parameters so the M stage can reuse it for data.
module fetch_exc_chk
  import mips_pkg::*;
#(
  parameter logic [31:0] LO   = mips_pkg::IM_LO,
  parameter logic [31:0] HI   = mips_pkg::IM_HI,
  parameter logic [4:0]  CODE = mips_pkg::EXC_ADEL
) (
  input  logic [31:0] pc,
  output logic        adel,
  output logic [4:0]  exc_code
);

  always_comb begin
    adel = (pc[1:0] != 2'b00) || (pc < LO) || (pc > HI);
    exc_code = adel ? CODE : EXC_NONE;
  end

endmodule

// File: rtl/if_id_reg.sv
// IF/ID pipeline register with fetch AdEL check,
// stall hold, flush bubble and saturating stall counter.
module if_id_reg
  import mips_pkg::*;
#(
  parameter logic [31:0] PC_RESET = mips_pkg::PC_RESET,
  parameter logic [31:0] IM_LO    = mips_pkg::IM_LO,
  parameter logic [31:0] IM_HI    = mips_pkg::IM_HI,
  parameter logic [4:0]  EXC_ADEL = mips_pkg::EXC_ADEL
) (
  input logic         Clk,
  input logic         Rst,
  if_id_reg_if.slave  bus
);

  localparam if_id_t RST_VAL = '{
    instr: NOP,
    pc:    PC_RESET,
    pc8:   PC_RESET + 32'd8,
    bd:    1'b0,
    exc:   EXC_NONE,
    valid: 1'b0
  };

  if_id_t      ifid_q, ifid_d;
  logic [15:0] stall_cnt_q, stall_cnt_d;
  logic        adel;
  logic [4:0]  adel_code;

  fetch_exc_chk #(
    .LO   (IM_LO),
    .HI   (IM_HI),
    .CODE (EXC_ADEL)
  ) u_chk (
    .pc       (bus.PC_F),
    .adel     (adel),
    .exc_code (adel_code)
  );

  always_comb begin
    ifid_d = ifid_q;
    if (bus.Flush) begin
      ifid_d.instr = NOP;
      ifid_d.pc    = bus.PC_F;
      ifid_d.pc8   = bus.PC8_F;
      ifid_d.bd    = 1'b0;
      ifid_d.exc   = EXC_NONE;
      ifid_d.valid = 1'b0;
    end else if (!bus.Stall) begin
      // a faulting fetch becomes a nop that still carries its PC
      ifid_d.instr = adel ? NOP : bus.Instr_F;
      ifid_d.pc    = bus.PC_F;
      ifid_d.pc8   = bus.PC8_F;
      ifid_d.bd    = bus.BD_F;
      ifid_d.exc   = adel_code;
      ifid_d.valid = 1'b1;
    end
  end

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (bus.Stall && !bus.Flush && stall_cnt_q != 16'hFFFF)
      stall_cnt_d = stall_cnt_q + 16'd1;
  end

  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      ifid_q      <= RST_VAL;
      stall_cnt_q <= 16'd0;
    end else begin
      ifid_q      <= ifid_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign bus.Instr_D   = ifid_q.instr;
  assign bus.PC_D      = ifid_q.pc;
  assign bus.PC8_D     = ifid_q.pc8;
  assign bus.BD_D      = ifid_q.bd;
  assign bus.ExcCode_D = ifid_q.exc;
  assign bus.Valid_D   = ifid_q.valid;
  assign bus.StallCnt  = stall_cnt_q;

endmodule
